// File: rtl/load_realign_unit_pkg.sv
// Shared definitions for the load realign unit: access size codes, FSM states, crossing test.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package load_realign_unit_pkg;

    // Access size codes as carried on in_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    // Load sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP1 = 3'd3,
        DONE = 3'd4
    } state_t;

    // True when the access spills past the last byte of its word
    function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_H) && (off == 2'd3)) ||
               ((size == SIZE_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/load_realign_unit_byte_lane_extract.sv
// Selects the addressed bytes from a two-word window and right-justifies/extends them.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module byte_lane_extract
    import load_realign_unit_pkg::*;
(
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] data32
);

    logic [31:0] shifted;

    // Little-endian window {word1,word0} shifted down by the byte offset, then width-extended
    always_comb begin
        shifted = 32'({word1, word0} >> {off, 3'b000});
        case (size)
            SIZE_B:  data32 = {{24{sgn & shifted[7]}},  shifted[7:0]};
            SIZE_H:  data32 = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: data32 = shifted;
        endcase
    end

endmodule

// File: rtl/load_realign_unit.sv
// Turns a byte-addressed load into one or two word reads and returns aligned, extended data.
// Latency: accept edge T -> out_valid at T+3 aligned, T+4 word-crossing, T+1 on error.
// Backpressure: one request in flight; in_ready only in IDLE, result held until out_ready.
module load_realign_unit
    import load_realign_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              mem_rd,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_err
);

    localparam int WI = ADDR_W - 2;

    state_t          state;
    logic [WI-1:0]   req_w;
    logic [1:0]      req_off;
    logic [1:0]      req_size;
    logic            req_sgn;
    logic            req_cross;
    logic [31:0]     word0_q;

    logic            acc_cross;
    logic            acc_err;
    logic [31:0]     ext_lo;
    logic [31:0]     ext_hi;
    logic [31:0]     ext_data;

    assign in_ready = (state == IDLE);

    // Classify the incoming request: crossing accesses are errors only when splitting is disabled
    always_comb begin
        acc_cross = is_cross(in_size, in_addr[1:0]);
        acc_err   = (in_size == SIZE_X) || (acc_cross && !SPLIT_EN);
    end

    // Read data is consumed straight off the memory bus on the cycle it arrives;
    // for a split access the first word comes from the capture register
    always_comb begin
        ext_lo = mem_rdata;
        ext_hi = 32'd0;
        if (state == CAP1) begin
            ext_lo = word0_q;
            ext_hi = mem_rdata;
        end
    end

    byte_lane_extract u_extract (
        .word0  (ext_lo),
        .word1  (ext_hi),
        .off    (req_off),
        .size   (req_size),
        .sgn    (req_sgn),
        .data32 (ext_data)
    );

    // Request FSM with registered memory strobe/index and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_w     <= '0;
            req_off   <= 2'd0;
            req_size  <= SIZE_B;
            req_sgn   <= 1'b0;
            req_cross <= 1'b0;
            word0_q   <= 32'd0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req_w     <= in_addr[ADDR_W-1:2];
                        req_off   <= in_addr[1:0];
                        req_size  <= in_size;
                        req_sgn   <= in_signed;
                        req_cross <= acc_cross;
                        if (acc_err) begin
                            // No memory traffic for rejected requests
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_data  <= 32'd0;
                        end else begin
                            state    <= RD0;
                            mem_rd   <= 1'b1;
                            mem_addr <= in_addr[ADDR_W-1:2];
                        end
                    end
                end
                RD0: begin
                    // Second read goes out back-to-back; index wraps naturally at WI bits
                    state <= RD1;
                    if (req_cross) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= req_w + WI'(1);
                    end else begin
                        mem_rd <= 1'b0;
                    end
                end
                RD1: begin
                    word0_q <= mem_rdata;
                    mem_rd  <= 1'b0;
                    if (req_cross) begin
                        state <= CAP1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_data  <= ext_data;
                    end
                end
                CAP1: begin
                    mem_rd    <= 1'b0;
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_err   <= 1'b0;
                    out_data  <= ext_data;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_rd    <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_realign_unit.sv
// Bench for load_realign_unit: directed cases then random loads against a byte-level reference.
// Latency: checks T+1 / T+3 / T+4 result timing from the accept edge.
// Backpressure: holds out_ready low to check result stability and in_ready.
module tb_load_realign_unit;
    import load_realign_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_addr   [2];
    logic [1:0]  in_size   [2];
    logic        in_signed [2];
    logic        mem_rd    [2];
    logic [29:0] mem_addr  [2];
    logic [31:0] mem_rdata [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        out_err   [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [int unsigned];
    logic [29:0] rdlog0 [$];
    logic [29:0] rdlog1 [$];

    always #5 clk = ~clk;

    load_realign_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_addr(in_addr[0]),
        .in_size(in_size[0]), .in_signed(in_signed[0]),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_err(out_err[0])
    );

    load_realign_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_nosplit (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_addr(in_addr[1]),
        .in_size(in_size[1]), .in_signed(in_signed[1]),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_err(out_err[1])
    );

    // Word contents: explicit entries, else a fixed scramble of the index
    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        int unsigned k;
        k = 32'(idx);
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Synchronous memories, one per DUT, plus a log of every read strobe
    always @(posedge clk) begin
        if (mem_rd[0]) begin
            mem_rdata[0] <= mem_word(mem_addr[0]);
            rdlog0.push_back(mem_addr[0]);
        end
        if (mem_rd[1]) begin
            mem_rdata[1] <= mem_word(mem_addr[1]);
            rdlog1.push_back(mem_addr[1]);
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", name, obs, exp);
        end
    endtask

    // Byte-at-a-time reference: gather n bytes from consecutive byte addresses
    task automatic ref_load(input logic [31:0] a, input logic [1:0] size, input logic sgn,
                            input bit split, output logic [31:0] d, output bit err,
                            output int nrd, output logic [29:0] w0, output logic [29:0] w1);
        int n;
        logic [31:0] ba;
        logic [31:0] wv;
        logic [31:0] last;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        d   = 32'd0;
        err = 1'b0;
        nrd = 0;
        w0  = a[31:2];
        last = a + 32'(n - 1);
        w1  = last[31:2];
        if (size == 2'd3 || (w1 != w0 && !split)) begin
            err = 1'b1;
            return;
        end
        nrd = (w1 != w0) ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            wv = mem_word(ba[31:2]) >> (8 * ba[1:0]);
            d  = d | ({24'd0, wv[7:0]} << (8 * i));
        end
        if (sgn && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
    endtask

    // One complete load: issue, time the result, optionally stall, handshake, check reads
    task automatic do_load(input int s, input logic [31:0] a, input logic [1:0] size,
                           input logic sgn, input int hold, input string tag,
                           output logic [31:0] got);
        logic [31:0] ed;
        bit          ee;
        int          enr;
        logic [29:0] ew0, ew1;
        int          lat;
        int          nobs;
        ref_load(a, size, sgn, (s == 0), ed, ee, enr, ew0, ew1);
        chk({tag, "_in_ready"}, 32'(in_ready[s]), 32'd1);
        rdlog0.delete();
        rdlog1.delete();
        in_valid[s]  = 1'b1;
        in_addr[s]   = a;
        in_size[s]   = size;
        in_signed[s] = sgn;
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        lat = 1;
        while (!out_valid[s] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), ee ? 32'd1 : (enr == 2 ? 32'd4 : 32'd3));
        chk({tag, "_data"}, out_data[s], ed);
        chk({tag, "_err"}, 32'(out_err[s]), 32'(ee));
        got = out_data[s];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(out_valid[s]), 32'd1);
            chk({tag, "_hold_data"}, out_data[s], ed);
            chk({tag, "_hold_in_ready"}, 32'(in_ready[s]), 32'd0);
        end
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[s] = 1'b0;
        chk({tag, "_after_valid"}, 32'(out_valid[s]), 32'd0);
        nobs = (s == 0) ? rdlog0.size() : rdlog1.size();
        chk({tag, "_nreads"}, 32'(nobs), 32'(enr));
        if (nobs == enr && enr >= 1)
            chk({tag, "_rd0_addr"}, 32'((s == 0) ? rdlog0[0] : rdlog1[0]), 32'(ew0));
        if (nobs == enr && enr == 2)
            chk({tag, "_rd1_addr"}, 32'((s == 0) ? rdlog0[1] : rdlog1[1]), 32'(ew1));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] ra;
        int          rs;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_addr[i]   = 32'd0;
            in_size[i]   = 2'd0;
            in_signed[i] = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready",  32'(in_ready[0]),  32'd1);
        chk("rst_mem_rd",    32'(mem_rd[0]),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr[0]),  32'd0);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_data",  out_data[0],       32'd0);
        chk("rst_out_err",   32'(out_err[0]),   32'd0);

        // Aligned word
        mem[32'h41] = 32'hDEADBEEF;
        do_load(0, 32'h0000_0104, SIZE_W, 1'b0, 0, "t1_word", got);
        chk("t1_literal", got, 32'hDEADBEEF);

        // Byte lane 3, signed and unsigned
        mem[32'h41] = 32'h80FF00FF;
        do_load(0, 32'h0000_0107, SIZE_B, 1'b1, 0, "t2_bs", got);
        chk("t2_bs_literal", got, 32'hFFFFFF80);
        do_load(0, 32'h0000_0107, SIZE_B, 1'b0, 0, "t2_bu", got);
        chk("t2_bu_literal", got, 32'h00000080);

        // Halfword split across two words
        mem[32'h40] = 32'hAA000000;
        mem[32'h41] = 32'h000000BB;
        do_load(0, 32'h0000_0103, SIZE_H, 1'b0, 0, "t3_half", got);
        chk("t3_literal", got, 32'h0000BBAA);

        // Errors: crossing with splitting disabled, illegal size
        do_load(1, 32'h0000_0102, SIZE_W, 1'b0, 0, "t4_nosplit", got);
        do_load(1, 32'h0000_0104, SIZE_X, 1'b0, 0, "t4_nosplit_x", got);
        do_load(0, 32'h0000_0104, SIZE_X, 1'b1, 0, "t4_size_x", got);
        do_load(1, 32'h0000_0104, SIZE_W, 1'b0, 0, "t4_nosplit_ok", got);

        // Word index wrap
        mem[32'h3FFFFFFF] = 32'h44332211;
        mem[32'h0]        = 32'h88776655;
        do_load(0, 32'hFFFF_FFFE, SIZE_W, 1'b0, 0, "t5_wrap", got);
        chk("t5_literal", got, 32'h66554433);

        // Consumer stall
        do_load(0, 32'h0000_0105, SIZE_H, 1'b1, 5, "t6_hold", got);

        // Reset while the second read of a split access is outstanding
        in_valid[0]  = 1'b1;
        in_addr[0]   = 32'h0000_0103;
        in_size[0]   = SIZE_H;
        in_signed[0] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t6_rst_in_ready",  32'(in_ready[0]),  32'd1);
        chk("t6_rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("t6_rst_mem_rd",    32'(mem_rd[0]),    32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("t6_rst_quiet", 32'(out_valid[0]), 32'd0);
        end
        do_load(0, 32'h0000_0106, SIZE_W, 1'b0, 0, "t6_post_rst", got);

        // Random loads over two address regions, one straddling the top of memory
        for (int i = 0; i < 16; i++) mem[32'h80 + i] = $urandom;
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                              : (32'h0000_0200 + $urandom_range(0, 60));
            rs = ($urandom_range(0, 3) == 0) ? 1 : 0;
            do_load(rs, ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $sformatf("rnd%0d", i), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
